// File: rtl/uart_cmd_rx_if.sv
// Byte handshake between the UART command receiver and the auth state machine.
interface uart_cmd_rx_if;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (output clr_rdy, input rx_data, rdy, frm_err, ovr_err);
  modport slave  (input clr_rdy, output rx_data, rdy, frm_err, ovr_err);
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with mid-bit sampling, rdy/clr_rdy handshake and sticky
// framing/overrun flags.
module uart_cmd_rx #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  uart_cmd_rx_if.slave  bus
);

  localparam int BW = $clog2(BAUD_CYCLES);
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_CYCLES / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdy_q, rdy_d;
  logic            frm_err_q, frm_err_d;
  logic            ovr_err_q, ovr_err_d;
  logic            bcnt_zero;
  logic            good_stop;
  logic            bad_stop;

  assign bcnt_zero = (bcnt_q == '0);
  assign good_stop = (state_q == STOP) && bcnt_zero && rx_s_q;
  assign bad_stop  = (state_q == STOP) && bcnt_zero && !rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s_q) state_d = START;
      START:   if (bcnt_zero) state_d = rx_s_q ? IDLE : DATA;
      DATA:    if (bcnt_zero && (bitcnt_q == 4'd7)) state_d = STOP;
      STOP:    if (bcnt_zero) state_d = rx_s_q ? IDLE : BRK;
      BRK:     if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flag updates give a set priority over clr_rdy so a byte landing on the
  // acknowledge edge is never lost.
  always_comb begin
    bcnt_d    = bcnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) bcnt_d = HALF_LOAD;
      end
      START: begin
        if (bcnt_zero) begin
          bcnt_d   = FULL_LOAD;
          bitcnt_d = 4'd0;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bcnt_zero) begin
          bcnt_d   = FULL_LOAD;
          shreg_d  = {rx_s_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      STOP: begin
        if (!bcnt_zero) bcnt_d = bcnt_q - 1'b1;
      end
      default: ;
    endcase

    if (good_stop) rx_data_d = shreg_q;

    rdy_d = rdy_q;
    if (good_stop)        rdy_d = 1'b1;
    else if (bus.clr_rdy) rdy_d = 1'b0;

    ovr_err_d = ovr_err_q;
    if (good_stop && rdy_q) ovr_err_d = 1'b1;
    else if (bus.clr_rdy)   ovr_err_d = 1'b0;

    frm_err_d = frm_err_q;
    if (bad_stop)         frm_err_d = 1'b1;
    else if (bus.clr_rdy) frm_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      bcnt_q    <= '0;
      bitcnt_q  <= 4'd0;
      shreg_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      bcnt_q    <= bcnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit: a table of frames plus
// hand-written latency, glitch, handshake-collision and reset sequences.
module tb_uart_cmd_rx;

  localparam int BAUD = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       stop_bit;
    logic       clr_before;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_frm;
    logic       exp_ovr;
  } vec_t;

  logic clk;
  logic rst;
  logic rx;
  int   n_checks;
  int   n_fail;
  vec_t vecs [8];

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(.BAUD_CYCLES(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] d, input logic r,
                           input logic f, input logic o);
    check_output({name, "_data"}, bus.rx_data, d);
    check_output({name, "_rdy"}, {7'd0, bus.rdy}, {7'd0, r});
    check_output({name, "_frm"}, {7'd0, bus.frm_err}, {7'd0, f});
    check_output({name, "_ovr"}, {7'd0, bus.ovr_err}, {7'd0, o});
  endtask

  // One full 8N1 frame; optional 3-clock high glitch at the start of bit 0.
  task automatic apply_stimulus(input logic [7:0] d, input logic sb, input logic glitch);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 0) begin
        rx = 1'b1;
        tick(3);
        rx = d[0];
        tick(BAUD - 3);
      end else begin
        rx = d[i];
        tick(BAUD);
      end
    end
    rx = sb;
    tick(BAUD);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rx          = 1'b1;
    bus.clr_rdy = 1'b0;
    rst         = 1'b1;

    vecs[0] = '{8'h67, 1'b1, 1'b1, 8'h67, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h73, 1'b1, 1'b1, 8'h73, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h67, 1'b1, 1'b0, 8'h67, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h73, 1'b1, 1'b0, 8'h73, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'h73, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    tick(3);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4);
    check_all("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Start bit driven just after edge k: rdy must rise exactly at edge k+155.
    fork
      apply_stimulus(8'h67, 1'b1, 1'b0);
      begin
        tick(154);
        check_output("latency_early", {7'd0, bus.rdy}, 8'h00);
        tick(1);
        check_output("latency_rdy", {7'd0, bus.rdy}, 8'h01);
      end
    join
    tick(4);
    check_all("first_byte", 8'h67, 1'b1, 1'b0, 1'b0);

    bus.clr_rdy = 1'b1;
    check_output("clr_pre_edge", {7'd0, bus.rdy}, 8'h01);
    tick(1);
    bus.clr_rdy = 1'b0;
    check_output("clr_next_edge", {7'd0, bus.rdy}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr_before) pulse_clr();
      apply_stimulus(vecs[i].data, vecs[i].stop_bit, 1'b0);
      tick(4);
      check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rdy,
                vecs[i].exp_frm, vecs[i].exp_ovr);
    end

    pulse_clr();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check_all("short_low", 8'hFF, 1'b0, 1'b0, 1'b0);

    apply_stimulus(8'h5A, 1'b1, 1'b1);
    tick(4);
    check_all("glitch", 8'h5A, 1'b1, 1'b0, 1'b0);

    // clr_rdy held through the whole frame: the set edge wins, the next clears.
    bus.clr_rdy = 1'b1;
    fork
      apply_stimulus(8'h3C, 1'b1, 1'b0);
      begin
        tick(155);
        check_output("collide_set", {7'd0, bus.rdy}, 8'h01);
        check_output("collide_ovr", {7'd0, bus.ovr_err}, 8'h00);
        tick(1);
        check_output("collide_clr", {7'd0, bus.rdy}, 8'h00);
      end
    join
    bus.clr_rdy = 1'b0;
    tick(4);
    check_output("collide_data", bus.rx_data, 8'h3C);

    rx = 1'b0;
    tick(40);
    rst = 1'b1;
    #1;
    check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(2);
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(30);
    check_all("after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    apply_stimulus(8'h67, 1'b1, 1'b0);
    tick(4);
    check_all("clean_after_reset", 8'h67, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
